// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus per-bit tick-qualified debouncer for the slide switches.
// Define SW_DEBOUNCE_EDGE_EN to build the registered sw_rise / sw_fall pulses; otherwise they are tied low.
module sw_debounce #(
    parameter int WIDTH        = 16,
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = $clog2(STABLE_TICKS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [WIDTH-1:0]            s1_q, s1_d;
    logic [WIDTH-1:0]            sync_q, sync_d;
    logic [DIV_W-1:0]            div_q, div_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]            clean_q, clean_d;
    logic                        tick;

    assign tick = (div_q == DIV_LAST);

    always_comb begin
        s1_d   = sw_raw;
        sync_d = s1_q;
        div_d  = tick ? '0 : div_q + 1'b1;
    end

    // A bounce back to the accepted level restarts qualification even on a tick edge.
    always_comb begin
        clean_d = clean_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_q[i] == clean_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick && (cnt_q[i] == CNT_LAST)) begin
                clean_d[i] = sync_q[i];
                cnt_d[i]   = '0;
            end else if (tick) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            sync_q  <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            clean_q <= '0;
        end else begin
            s1_q    <= s1_d;
            sync_q  <= sync_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign sw_clean = clean_q;

`ifdef SW_DEBOUNCE_EDGE_EN
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;

    // Derived from the next clean value so the pulse lands on the same edge as the update.
    always_comb begin
        rise_d = clean_d & ~clean_q;
        fall_d = ~clean_d & clean_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sw_rise = rise_q;
    assign sw_fall = fall_q;
`else
    assign sw_rise = '0;
    assign sw_fall = '0;
`endif
endmodule
